data_mem: RTL and testbench

Data-memory responder on the far side of the CPU's MEM-stage bus. Serves the pipeline's 64-bit load/store traffic over the shared bidirectional data bus:
- Reads return combinationally within the MEM cycle.
- Writes are posted through a one-entry write buffer with read forwarding.
- Sticky error flags and saturating access counters are exposed for debug.

---
 rtl/mem_pkg.sv | 14 +
 rtl/data_mem_if.sv | 24 ++
 rtl/data_mem_wbuf.sv | 44 ++++
 rtl/data_mem.sv | 97 +++++++++
 tb/tb_data_mem.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data bus.
// Bus width, read/write encodings and debug counter width.
package mem_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/data_mem_if.sv
// MEM-stage request/debug bundle between CPU (master) and data_mem (slave).
// Ports: mem_addr/mem_rw/mem_en from CPU; sticky errors and counters back.
interface data_mem_if;
  import mem_pkg::*;

  logic [63:0] mem_addr;
  logic        mem_rw;
  logic        mem_en;
  logic        err_misaligned;
  logic        err_range;
  cnt_t        rd_count;
  cnt_t        wr_count;

  modport master (
    output mem_addr, mem_rw, mem_en,
    input  err_misaligned, err_range, rd_count, wr_count
  );

  modport slave (
    input  mem_addr, mem_rw, mem_en,
    output err_misaligned, err_range, rd_count, wr_count
  );

endinterface

// File: rtl/data_mem_wbuf.sv
// One-entry posted write buffer with read forwarding.
// Ports: capture in (cap_*), commit out (commit_*), forwarded read data.
module data_mem_wbuf
  import mem_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [IDX_W-1:0] cap_idx,
  input  word_t            cap_data,
  input  logic [IDX_W-1:0] rd_idx,
  input  word_t            arr_data,
  output logic             commit_en,
  output logic [IDX_W-1:0] commit_idx,
  output word_t            commit_data,
  output word_t            fwd_data
);

  logic             valid;
  logic [IDX_W-1:0] idx;
  word_t            data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else begin
      valid <= cap_en;
    end
    if (cap_en) begin
      idx  <= cap_idx;
      data <= cap_data;
    end
  end

  // A pending entry at a reset edge is dropped, not written back.
  assign commit_en   = valid & ~rst;
  assign commit_idx  = idx;
  assign commit_data = data;

  assign fwd_data = (valid && idx == rd_idx) ? data : arr_data;

endmodule

// File: rtl/data_mem.sv
// Data-memory responder on the MEM-stage bus: 0-latency reads, posted writes.
// Ports: clk, rst, bus (data_mem_if.slave), mem_data (shared inout bus).
module data_mem #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_if.slave         bus,
  inout  wire  [DATA_W-1:0] mem_data
);
  import mem_pkg::*;

  word_t arr [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             out_range;
  logic             legal;
  logic             acc;
  logic             do_wr;
  logic             do_rd;

  logic             commit_en;
  logic [IDX_W-1:0] commit_idx;
  word_t            commit_data;
  word_t            fwd_data;
  word_t            rd_data;

  logic             err_mis;
  logic             err_rng;
  cnt_t             rd_cnt;
  cnt_t             wr_cnt;

  assign idx        = bus.mem_addr[3 +: IDX_W];
  assign misaligned = |bus.mem_addr[2:0];
  assign out_range  = |(bus.mem_addr >> (3 + IDX_W));
  assign legal      = ~misaligned & ~out_range;

  assign acc   = bus.mem_en & ~rst;
  assign do_wr = acc & (bus.mem_rw == MEM_WRITE);
  assign do_rd = acc & (bus.mem_rw == MEM_READ);

  data_mem_wbuf #(
    .IDX_W (IDX_W)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .cap_en      (do_wr & legal),
    .cap_idx     (idx),
    .cap_data    (mem_data),
    .rd_idx      (idx),
    .arr_data    (arr[idx]),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .fwd_data    (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (commit_en) begin
      arr[commit_idx] <= commit_data;
    end
  end

  assign rd_data  = legal ? fwd_data : '0;
  assign mem_data = (bus.mem_rw == MEM_READ && !rst) ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_mis <= 1'b0;
      err_rng <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if (acc && misaligned) begin
        err_mis <= 1'b1;
      end
      if (acc && out_range) begin
        err_rng <= 1'b1;
      end
      if (do_rd && rd_cnt != '1) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (do_wr && wr_cnt != '1) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  assign bus.err_misaligned = err_mis;
  assign bus.err_range      = err_rng;
  assign bus.rd_count       = rd_cnt;
  assign bus.wr_count       = wr_cnt;

endmodule

// File: tb/tb_data_mem.sv
// Randomized self-checking bench for data_mem against a word-array model.
// Directed literal checks first, then random traffic with occasional reset.
module tb_data_mem;
  import mem_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] tb_val = '0;
  wire  [63:0] mem_data;
  wire         tb_drv;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_if bus ();

  data_mem #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_data (mem_data)
  );

  assign tb_drv   = bus.mem_rw | rst;
  assign mem_data = tb_drv ? tb_val : 'z;

  // Behavioural model: a write is visible in the array as soon as it is
  // accepted; the most recent accepted write is undone by a reset edge.
  logic [63:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          pend = 0;
  int          pend_idx = 0;
  logic [63:0] pend_old = '0;
  bit          pend_oldk = 0;
  bit          m_mis = 0;
  bit          m_rng = 0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_wr = '0;
  bit          started = 0;
  int          sat_req = 0;
  int          sat_seen = 0;

  function automatic bit addr_legal(input logic [63:0] a);
    return (a % 8 == 0) && (a / 8 < DEPTH);
  endfunction

  always @(posedge clk) begin
    if (sat_req != sat_seen) begin
      m_rd = '1;
      sat_seen = sat_req;
    end
    if (rst) begin
      if (pend) begin
        m_mem[pend_idx]   = pend_old;
        m_known[pend_idx] = pend_oldk;
      end
      pend    = 0;
      m_mis   = 0;
      m_rng   = 0;
      m_rd    = '0;
      m_wr    = '0;
      started = 1;
    end else begin
      pend = 0;
      if (bus.mem_en) begin
        if (bus.mem_addr % 8 != 0) m_mis = 1;
        if (bus.mem_addr / 8 >= DEPTH) m_rng = 1;
        if (bus.mem_rw) begin
          if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
          if (addr_legal(bus.mem_addr)) begin
            pend_idx  = int'(bus.mem_addr / 8);
            pend      = 1;
            pend_old  = m_mem[pend_idx];
            pend_oldk = m_known[pend_idx];
            m_mem[pend_idx]   = mem_data;
            m_known[pend_idx] = 1;
          end
        end else begin
          if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
        end
      end
    end
  end

  function automatic void chk(input string n, input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (started) begin
      if (tb_drv) begin
        chk("bus_ext", mem_data, tb_val);
      end else if (!addr_legal(bus.mem_addr)) begin
        chk("bus_illegal", mem_data, 64'd0);
      end else if (m_known[int'(bus.mem_addr / 8)]) begin
        chk("bus_rd", mem_data, m_mem[int'(bus.mem_addr / 8)]);
      end
      chk("err_misaligned", {63'd0, bus.err_misaligned}, {63'd0, m_mis});
      chk("err_range", {63'd0, bus.err_range}, {63'd0, m_rng});
      chk("rd_count", {32'd0, bus.rd_count}, {32'd0, m_rd});
      chk("wr_count", {32'd0, bus.wr_count}, {32'd0, m_wr});
    end
  end

  task automatic drive(input logic r, input logic en, input logic rw,
                       input logic [63:0] a, input logic [63:0] d);
    @(posedge clk);
    #1;
    rst          = r;
    bus.mem_en   = en;
    bus.mem_rw   = rw;
    bus.mem_addr = a;
    tb_val       = rw ? d : 64'd0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    int          k;
    bus.mem_en   = 1'b0;
    bus.mem_rw   = MEM_READ;
    bus.mem_addr = '0;

    drive(1, 0, MEM_READ, 0, 0);
    drive(1, 0, MEM_READ, 0, 0);
    chk("lit_rst_rd", {32'd0, bus.rd_count}, 64'd0);
    chk("lit_rst_bus", mem_data, 64'd0);

    drive(0, 1, MEM_WRITE, 64'h10, 64'hDEAD_BEEF_0000_0001);
    drive(0, 1, MEM_READ, 64'h10, 0);
    chk("lit_fwd", mem_data, 64'hDEAD_BEEF_0000_0001);
    drive(0, 0, MEM_READ, 64'h10, 0);
    drive(0, 1, MEM_READ, 64'h10, 0);
    chk("lit_arr", mem_data, 64'hDEAD_BEEF_0000_0001);
    drive(0, 0, MEM_READ, 0, 0);
    chk("lit_rd2", {32'd0, bus.rd_count}, 64'd2);
    chk("lit_wr1", {32'd0, bus.wr_count}, 64'd1);

    drive(0, 1, MEM_WRITE, 64'h8, 64'h11);
    drive(0, 1, MEM_WRITE, 64'h8, 64'h22);
    drive(0, 0, MEM_READ, 64'h8, 0);
    drive(0, 1, MEM_READ, 64'h8, 0);
    chk("lit_b2b", mem_data, 64'h22);

    drive(0, 1, MEM_READ, 64'h0C, 0);
    chk("lit_mis_bus", mem_data, 64'd0);
    drive(0, 1, MEM_READ, 64'h10, 0);
    chk("lit_mis_set", {63'd0, bus.err_misaligned}, 64'd1);
    drive(0, 1, MEM_WRITE, 64'h10, 64'h5);
    drive(0, 1, MEM_READ, 64'h10, 0);
    chk("lit_mis_sticky", {63'd0, bus.err_misaligned}, 64'd1);

    drive(0, 1, MEM_WRITE, 64'h0, 64'h55);
    drive(0, 1, MEM_WRITE, DEPTH * 8, 64'hBAD);
    drive(0, 1, MEM_READ, 64'h0, 0);
    chk("lit_rng_drop", mem_data, 64'h55);
    drive(0, 1, MEM_READ, DEPTH * 8, 0);
    chk("lit_rng_bus", mem_data, 64'd0);
    drive(0, 0, MEM_READ, 0, 0);
    chk("lit_rng_set", {63'd0, bus.err_range}, 64'd1);

    drive(0, 1, MEM_WRITE, 64'h18, 64'h77);
    drive(0, 1, MEM_WRITE, 64'h18, 64'h99);
    drive(1, 0, MEM_READ, 64'h18, 0);
    chk("lit_rst_release", mem_data, 64'd0);
    drive(1, 0, MEM_WRITE, 64'h18, 64'hAB);
    chk("lit_rst_hiz", mem_data, 64'hAB);
    drive(0, 1, MEM_READ, 64'h18, 0);
    chk("lit_pend_drop", mem_data, 64'h77);
    chk("lit_rst_cnt", {bus.rd_count, bus.wr_count}, 64'd0);

    drive(0, 0, MEM_READ, 0, 0);
    #2;
    force dut.rd_cnt = 32'hFFFF_FFFF;
    sat_req++;
    #1;
    release dut.rd_cnt;
    drive(0, 1, MEM_READ, 0, 0);
    drive(0, 0, MEM_READ, 0, 0);
    chk("lit_sat", {32'd0, bus.rd_count}, 64'hFFFF_FFFF);

    for (int n = 0; n < 500; n++) begin
      k = int'($urandom_range(0, 9));
      a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      if (k == 7) a = a | 64'($urandom_range(1, 7));
      if (k == 8) a = 64'($urandom_range(DEPTH, 3 * DEPTH)) << 3;
      if (k == 9) a = a | (64'd1 << $urandom_range(7, 63));
      d = {$urandom, $urandom};
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, a, d);
    end
    drive(0, 0, MEM_READ, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
